// File: rtl/id_ex_pkg.sv
// Types and constants shared by the ID/EX pipeline register.
// Provides the beat payload struct, its bubble value and occupancy decode.
`ifndef INST_NOP
`include "defines.sv"
`endif

package id_ex_pkg;

    // One decoded beat as carried from decode to execute
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] inst_addr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd_addr;
        logic        reg_wen;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    // Value presented downstream whenever no beat is valid
    localparam beat_t BUBBLE = '{
        inst:      `INST_NOP,
        inst_addr: `ZERO_WORD,
        op1:       `ZERO_WORD,
        op2:       `ZERO_WORD,
        rd_addr:   5'd0,
        reg_wen:   1'b0
    };

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_FULL
    } occ_e;

    // Occupancy is a pure view of the two valid bits; S is only ever
    // valid while M is valid, so s alone implies FULL.
    function automatic occ_e occ_of(input logic m_v, input logic s_v);
        occ_e o;
        if (s_v) begin
            o = OCC_FULL;
        end else if (m_v) begin
            o = OCC_ONE;
        end else begin
            o = OCC_EMPTY;
        end
        return o;
    endfunction

endpackage

// File: rtl/defines.sv
// Shared instruction/data constants for the decode/execute datapath.
// Guarded so that any number of files may pull it in.
`ifndef ID_EX_DEFINES_SV
`define ID_EX_DEFINES_SV

// addi x0, x0, 0: the canonical RISC-V bubble instruction
`define INST_NOP  32'h00000013
`define ZERO_WORD 32'h00000000

`endif

// File: rtl/dff_set.sv
// Generic storage register with async active-low reset and hold enable.
// Ports: clk, rst (active-low), hold_en (1 = keep), d_i -> q_o.
module dff_set #(
    parameter int              DW      = 32,
    parameter logic [DW-1:0]   RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold_en,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_o <= RST_VAL;
        end else if (!hold_en) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/id_ex.sv
// ID/EX pipeline register: two-entry skid buffer between decode and execute.
// Ports: clk, rst (async active-low); in_valid/in_ready + decoded payload in;
//        out_valid/out_ready + registered payload out; flush kills all beats.
import id_ex_pkg::*;

module id_ex (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        reg_wen_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic [31:0] op1_o,
    output logic [31:0] op2_o,
    output logic [4:0]  rd_addr_o,
    output logic        reg_wen_o,
    input  logic        flush
);

    logic  m_valid_d, m_valid_q;
    logic  s_valid_d, s_valid_q;
    beat_t m_pay_d, m_pay_q;
    beat_t s_pay_d, s_pay_q;
    logic  m_load, s_load;
    beat_t beat_in, beat_out;
    logic  accept, retire;
    occ_e  occ;

    assign beat_in = '{
        inst:      inst_i,
        inst_addr: inst_addr_i,
        op1:       op1_i,
        op2:       op2_i,
        rd_addr:   rd_addr_i,
        reg_wen:   reg_wen_i
    };

    // in_ready comes straight from the S valid flop, so out_ready never
    // reaches it combinationally; S exists to absorb that one-cycle lag.
    assign in_ready = !s_valid_q;
    assign accept   = in_valid && in_ready;
    assign retire   = m_valid_q && out_ready;
    assign occ      = occ_of(m_valid_q, s_valid_q);

    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_load    = 1'b0;
        s_load    = 1'b0;
        m_pay_d   = beat_in;
        s_pay_d   = beat_in;
        if (flush) begin
            // Stale payload is left in place; it is masked at the outputs
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else begin
            unique case (occ)
                OCC_EMPTY: begin
                    if (accept) begin
                        m_valid_d = 1'b1;
                        m_load    = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (accept && retire) begin
                        m_load = 1'b1;
                    end else if (accept) begin
                        s_valid_d = 1'b1;
                        s_load    = 1'b1;
                    end else if (retire) begin
                        m_valid_d = 1'b0;
                    end
                end
                OCC_FULL: begin
                    // in_ready is low here, so only a retire can happen
                    if (retire) begin
                        m_pay_d   = s_pay_q;
                        m_load    = 1'b1;
                        s_valid_d = 1'b0;
                    end
                end
                default: begin
                    m_valid_d = 1'b0;
                    s_valid_d = 1'b0;
                end
            endcase
        end
    end

    dff_set #(.DW(1), .RST_VAL(1'b0)) u_m_valid (
        .clk     (clk),
        .rst     (rst),
        .hold_en (1'b0),
        .d_i     (m_valid_d),
        .q_o     (m_valid_q)
    );

    dff_set #(.DW(1), .RST_VAL(1'b0)) u_s_valid (
        .clk     (clk),
        .rst     (rst),
        .hold_en (1'b0),
        .d_i     (s_valid_d),
        .q_o     (s_valid_q)
    );

    dff_set #(.DW(BEAT_W), .RST_VAL(BUBBLE)) u_m_pay (
        .clk     (clk),
        .rst     (rst),
        .hold_en (!m_load),
        .d_i     (m_pay_d),
        .q_o     (m_pay_q)
    );

    dff_set #(.DW(BEAT_W), .RST_VAL(BUBBLE)) u_s_pay (
        .clk     (clk),
        .rst     (rst),
        .hold_en (!s_load),
        .d_i     (s_pay_d),
        .q_o     (s_pay_q)
    );

    // Bubble masking also forces reg_wen_o low whenever nothing is valid
    assign beat_out    = m_valid_q ? m_pay_q : BUBBLE;
    assign out_valid   = m_valid_q;
    assign inst_o      = beat_out.inst;
    assign inst_addr_o = beat_out.inst_addr;
    assign op1_o       = beat_out.op1;
    assign op2_o       = beat_out.op2;
    assign rd_addr_o   = beat_out.rd_addr;
    assign reg_wen_o   = beat_out.reg_wen;

endmodule

// File: tb/tb_id_ex.sv
// Self-checking bench for id_ex: directed scenarios plus random traffic,
// compared against a queue-based model of a two-deep in-order buffer.
module tb_id_ex;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] inst_i = '0;
    logic [31:0] inst_addr_i = '0;
    logic [31:0] op1_i = '0;
    logic [31:0] op2_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        reg_wen_i = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic [31:0] op1_o;
    logic [31:0] op2_o;
    logic [4:0]  rd_addr_o;
    logic        reg_wen_o;
    logic        flush = 1'b0;

    always #5 clk = ~clk;

    id_ex dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .inst_i      (inst_i),
        .inst_addr_i (inst_addr_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .rd_addr_i   (rd_addr_i),
        .reg_wen_i   (reg_wen_i),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .inst_o      (inst_o),
        .inst_addr_o (inst_addr_o),
        .op1_o       (op1_o),
        .op2_o       (op2_o),
        .rd_addr_o   (rd_addr_o),
        .reg_wen_o   (reg_wen_o),
        .flush       (flush)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        wen;
    } mbeat_t;

    mbeat_t mq[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model view: buffer holds at most two beats, head is shown downstream
    task automatic check_all(input string tag);
        mbeat_t e;
        if (mq.size() > 0) begin
            e = mq[0];
        end else begin
            e = '{32'h00000013, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0};
        end
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, mq.size() > 0});
        chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, mq.size() < 2});
        chk({tag, ".inst"},      inst_o,             e.inst);
        chk({tag, ".addr"},      inst_addr_o,        e.addr);
        chk({tag, ".op1"},       op1_o,              e.op1);
        chk({tag, ".op2"},       op2_o,              e.op2);
        chk({tag, ".rd"},        {27'd0, rd_addr_o}, {27'd0, e.rd});
        chk({tag, ".wen"},       {31'd0, reg_wen_o}, {31'd0, e.wen});
    endtask

    task automatic tick(input string tag);
        int     n;
        logic   acc;
        mbeat_t b;
        @(posedge clk);
        b   = '{inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i};
        n   = mq.size();
        acc = in_valid && (n < 2);
        if (flush) begin
            mq.delete();
        end else begin
            if (n > 0 && out_ready) void'(mq.pop_front());
            if (acc) mq.push_back(b);
        end
        #1;
        check_all(tag);
    endtask

    task automatic put(input logic v, input logic [31:0] addr);
        in_valid    = v;
        inst_addr_i = addr;
        inst_i      = $urandom;
        op1_i       = $urandom;
        op2_i       = $urandom;
        rd_addr_i   = 5'($urandom);
        reg_wen_i   = 1'($urandom);
    endtask

    initial begin
        #3;
        check_all("reset");
        @(posedge clk);
        #1 rst = 1'b1;
        check_all("post_reset");

        // Single addi beat
        in_valid  = 1'b1;
        inst_i    = 32'h00500093;
        op1_i     = 32'd0;
        op2_i     = 32'd5;
        rd_addr_i = 5'd1;
        reg_wen_i = 1'b1;
        out_ready = 1'b1;
        tick("addi");
        chk("addi.inst_lit", inst_o, 32'h00500093);
        chk("addi.op2_lit", op2_o, 32'd5);
        in_valid = 1'b0;
        tick("addi_drain");

        // Back-to-back stream at full rate
        for (int i = 0; i < 8; i++) begin
            put(1'b1, 32'(i * 4));
            tick("stream");
            chk("stream.addr_lit", inst_addr_o, 32'(i * 4));
        end
        in_valid = 1'b0;
        tick("stream_drain");

        // Backpressure: third beat held by the source
        out_ready = 1'b0;
        put(1'b1, 32'h10);
        tick("bp0");
        put(1'b1, 32'h14);
        tick("bp1");
        chk("bp.in_ready_low", {31'd0, in_ready}, 32'd0);
        put(1'b1, 32'h18);
        tick("bp_hold0");
        tick("bp_hold1");
        out_ready = 1'b1;
        tick("bp_rel0");
        chk("bp.second", inst_addr_o, 32'h14);
        tick("bp_rel1");
        chk("bp.third", inst_addr_o, 32'h18);
        in_valid = 1'b0;
        tick("bp_drain");

        // Flush while full with a beat on the input
        out_ready = 1'b0;
        put(1'b1, 32'h20);
        tick("fl0");
        put(1'b1, 32'h24);
        tick("fl1");
        put(1'b1, 32'h28);
        flush = 1'b1;
        tick("flush");
        chk("flush.inst_lit", inst_o, 32'h00000013);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick("flush_after");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            put(($urandom_range(3) != 0), $urandom);
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(15) == 0);
            tick("rand");
        end
        flush    = 1'b0;
        in_valid = 1'b0;

        // Asynchronous reset while full
        out_ready = 1'b0;
        put(1'b1, 32'h40);
        tick("ar0");
        put(1'b1, 32'h44);
        tick("ar1");
        in_valid = 1'b0;
        #2 rst = 1'b0;
        mq.delete();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        rst       = 1'b1;
        out_ready = 1'b1;
        put(1'b1, 32'h80);
        tick("rst_release");
        chk("rst_release.addr_lit", inst_addr_o, 32'h80);
        in_valid = 1'b0;
        tick("end_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex.md
ID_EX -- requirements
Module: id_ex

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: in_valid  input  1 and in_ready  output  1  decode-side handshake.
REQ-004 SHALL have ports: inst_i, inst_addr_i, op1_i, op2_i  input  32 each; rd_addr_i  input  5; reg_wen_i  input  1  decoded beat payload.
REQ-005 SHALL have ports: out_valid  output  1 and out_ready  input  1  execute-side handshake.
REQ-006 SHALL have ports: inst_o, inst_addr_o, op1_o, op2_o  output  32 each; rd_addr_o  output  5; reg_wen_o  output  1  registered payload.
REQ-007 SHALL have port: flush  input  1  jump/branch-taken kill from execute.

Function
REQ-008 SHALL hold up to two beats: main entry M (drives outputs) and skid entry S; occupancy states EMPTY, ONE (M only), FULL (M and S).
REQ-009 SHALL accept a beat when in_valid && in_ready; SHALL retire M when out_valid && out_ready.
REQ-010 SHALL drive in_ready = !S_valid from a register only; no combinational path from out_ready to in_ready.
REQ-011 SHALL drive out_valid = M_valid.
REQ-012 SHALL give 1-cycle latency: beat accepted in cycle N appears on outputs with out_valid=1 in cycle N+1 when M empty or retiring.
REQ-013 SHALL sustain one beat per cycle when out_ready stays 1.
REQ-014 Transitions (no flush): EMPTY+accept->ONE; ONE+accept+retire->ONE (M<=input); ONE+accept+!retire->FULL (S<=input); ONE+retire+!accept->EMPTY; FULL+retire->ONE (M<=S, S cleared); FULL+!retire->FULL, payload unchanged.
REQ-015 SHALL keep beat order; no beat duplicated or lost except on flush.
REQ-016 flush SHALL take priority over accept and retire: next cycle M_valid=S_valid=0, the same-cycle incoming beat discarded.
REQ-017 While M_valid=0, outputs SHALL show bubble: inst_o=`INST_NOP (32'h00000013), inst_addr_o, op1_o, op2_o=0, rd_addr_o=0, reg_wen_o=0.
REQ-018 reg_wen_o SHALL be 0 whenever out_valid=0, regardless of stale payload.
REQ-019 Payload SHALL be stored unmodified (no sign extension or width change).
REQ-020 Stalled output (out_valid=1, out_ready=0) SHALL hold all outputs stable.

Reset
REQ-021 On rst=0, asynchronously: M_valid=S_valid=0, out_valid=0, in_ready=1, outputs at bubble values of REQ-017.
REQ-022 Reset mid-operation SHALL discard all held beats; first accept after release follows REQ-012.

Structure
REQ-023 `INST_NOP and `ZERO_WORD SHALL live in shared defines.v; no local literals for them.
REQ-024 Storage registers SHALL use one sub-module dff_set: parameterised width, async active-low reset to parameter default value, hold enable.
REQ-025 State SHALL be derived from M_valid/S_valid; no separate encoded state register.

Verification
REQ-026 Reset, then in_valid=1 inst_i=32'h00500093 op1_i=0 op2_i=5 rd_addr_i=1 reg_wen_i=1, out_ready=1 -> next cycle out_valid=1, inst_o=32'h00500093, op2_o=5, rd_addr_o=1, reg_wen_o=1.
REQ-027 Stream 8 beats inst_addr_i=0,4,...,28 with out_ready=1 -> out_valid high 8 consecutive cycles, inst_addr_o 0..28 in order, in_ready never 0.
REQ-028 out_ready=0, push addrs 0x10, 0x14, 0x18 -> in_ready=0 after second accept, 0x18 held by source; raise out_ready -> outputs 0x10, 0x14, 0x18 on consecutive cycles.
REQ-029 FULL (0x20, 0x24) plus in_valid beat 0x28 with flush=1 -> next cycle out_valid=0, inst_o=32'h00000013, reg_wen_o=0; 0x20-0x28 never appear.
REQ-030 rst=0 asserted mid-cycle while FULL -> outputs immediately bubble, in_ready=1 without waiting for a clock edge.
